// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: opcodes,
// fetch state encoding and reset vector.
package riscv_pkg;

  localparam logic [6:0] R_Type        = 7'h33;
  localparam logic [6:0] I_Type_LOGIC  = 7'h13;
  localparam logic [6:0] U_Type_LUI    = 7'h37;
  localparam logic [6:0] S_Type_SW     = 7'h23;
  localparam logic [6:0] I_Mem_Type_LW = 7'h03;
  localparam logic [6:0] J_Type_JAL    = 7'h6F;
  localparam logic [6:0] B_Type        = 7'h63;

  localparam logic [31:0] DEF_RESET_PC = 32'h0040_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  function automatic logic is_word_aligned(
    input logic [1:0] lsb
  );
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch address register; resets to the
// reset vector, loads on enable.
module fetch_pc_reg
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC =
    ADDR_WIDTH'(DEF_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] d,
  output logic [ADDR_WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, ready-based imem request,
// held instruction and next-PC selection.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC =
    ADDR_WIDTH'(DEF_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Advance_i,
  input  logic                  Branch_Taken_i,
  input  logic [ADDR_WIDTH-1:0] Branch_Target_i,
  output logic                  Mem_Req_o,
  output logic [ADDR_WIDTH-1:0] Mem_Addr_o,
  input  logic                  Mem_Ready_i,
  input  logic [31:0]           Mem_Rdata_i,
  output logic [ADDR_WIDTH-1:0] PC_o,
  output logic [31:0]           Instr_o,
  output logic [6:0]            OP_o,
  output logic                  Instr_Valid_o,
  output logic                  Misaligned_o
);

  fetch_state_e state, state_nxt;

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [31:0]           instr_q;
  logic                  pc_load;
  logic                  capture;

  fetch_pc_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc (
    .clk   (clk),
    .rst_n (reset),
    .load  (pc_load),
    .d     (next_pc),
    .q     (fetch_pc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_load   = 1'b0;
    capture   = 1'b0;
    next_pc   = Branch_Taken_i ? Branch_Target_i
                               : pc_q + ADDR_WIDTH'(4);
    unique case (state)
      FETCH: begin
        if (Mem_Ready_i) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (Advance_i) begin
          if (is_word_aligned(next_pc[1:0])) begin
            pc_load   = 1'b1;
            state_nxt = FETCH;
          end else begin
            state_nxt = FAULT;
          end
        end
      end
      FAULT: begin
        state_nxt = FAULT;
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  // Held word survives into FETCH/FAULT; only OP_o is masked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= '0;
      instr_q <= '0;
    end else if (capture) begin
      pc_q    <= fetch_pc;
      instr_q <= Mem_Rdata_i;
    end
  end

  assign Mem_Req_o     = (state == FETCH);
  assign Mem_Addr_o    = fetch_pc;
  assign Instr_Valid_o = (state == HOLD);
  assign Misaligned_o  = (state == FAULT);
  assign PC_o          = pc_q;
  assign Instr_o       = instr_q;
  assign OP_o          = Instr_Valid_o ? instr_q[6:0]
                                       : 7'h00;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with
// hand-computed expectations.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        adv;
  logic        br;
  logic [31:0] tgt;
  logic        req;
  logic [31:0] addr;
  logic        rdy;
  logic [31:0] rdata;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [6:0]  op;
  logic        vld;
  logic        mis;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk             (clk),
    .reset           (reset),
    .Advance_i       (adv),
    .Branch_Taken_i  (br),
    .Branch_Target_i (tgt),
    .Mem_Req_o       (req),
    .Mem_Addr_o      (addr),
    .Mem_Ready_i     (rdy),
    .Mem_Rdata_i     (rdata),
    .PC_o            (pc),
    .Instr_o         (instr),
    .OP_o            (op),
    .Instr_Valid_o   (vld),
    .Misaligned_o    (mis)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h",
               tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // fetch pending at a, return w with zero wait
  task automatic fetch0(
    input logic [31:0] a,
    input logic [31:0] w
  );
    check("fa_req", 32'(req), 32'd1);
    check("fa_addr", addr, a);
    rdy = 1'b1; rdata = w;
    step(1);
    rdy = 1'b0; rdata = 32'hDEAD_BEEF;
    check("fa_vld", 32'(vld), 32'd1);
    check("fa_pc", pc, a);
    check("fa_ins", instr, w);
    check("fa_op", 32'(op), 32'(w[6:0]));
    check("fa_noreq", 32'(req), 32'd0);
  endtask

  task automatic advance(
    input logic        b,
    input logic [31:0] t
  );
    adv = 1'b1; br = b; tgt = t;
    step(1);
    adv = 1'b0; br = 1'b0; tgt = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=1 want=0");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; adv = 1'b0; br = 1'b0;
    tgt = '0; rdy = 1'b0; rdata = '0;
    step(3);
    check("rst_req", 32'(req), 32'd1);
    check("rst_addr", addr, 32'h0040_0000);
    check("rst_pc", pc, 32'h0);
    check("rst_ins", instr, 32'h0);
    check("rst_op", 32'(op), 32'h0);
    check("rst_vld", 32'(vld), 32'd0);
    check("rst_mis", 32'(mis), 32'd0);
    reset = 1'b1;

    // zero-wait first fetch
    fetch0(32'h0040_0000, 32'h0050_0093);
    check("op_addi", 32'(op), 32'h13);

    // sequential advance: valid drops, OP masked
    advance(1'b0, 32'h0);
    check("adv_vld", 32'(vld), 32'd0);
    check("adv_op", 32'(op), 32'h0);
    check("adv_pc_kept", pc, 32'h0040_0000);
    check("adv_ins_kept", instr, 32'h0050_0093);

    // three wait states; stray Advance ignored
    for (int i = 0; i < 3; i++) begin
      check("ws_req", 32'(req), 32'd1);
      check("ws_addr", addr, 32'h0040_0004);
      check("ws_vld", 32'(vld), 32'd0);
      check("ws_op", 32'(op), 32'h0);
      adv = (i == 1); br = (i == 1);
      tgt = 32'h0000_0800;
      step(1);
    end
    adv = 1'b0; br = 1'b0;
    fetch0(32'h0040_0004, 32'h0000_0033);

    advance(1'b0, 32'h0);
    fetch0(32'h0040_0008, 32'h0080_006F);
    advance(1'b0, 32'h0);
    check("seq_addr", addr, 32'h0040_000C);
    fetch0(32'h0040_000C, 32'h0000_0063);

    advance(1'b1, 32'h0040_0100);
    check("br_addr", addr, 32'h0040_0100);
    check("br_mis", 32'(mis), 32'd0);
    fetch0(32'h0040_0100, 32'h0000_0063);

    // self-loop branch
    advance(1'b1, 32'h0040_0100);
    check("loop_addr", addr, 32'h0040_0100);
    check("loop_mis", 32'(mis), 32'd0);
    fetch0(32'h0040_0100, 32'h0000_0037);

    // wrap past top of address space
    advance(1'b1, 32'hFFFF_FFFC);
    fetch0(32'hFFFF_FFFC, 32'h0000_0013);
    advance(1'b0, 32'h0);
    check("wrap_addr", addr, 32'h0000_0000);
    check("wrap_mis", 32'(mis), 32'd0);
    check("wrap_req", 32'(req), 32'd1);
    fetch0(32'h0000_0000, 32'h0000_0023);

    // misaligned target -> sticky fault
    advance(1'b1, 32'h0040_0102);
    for (int i = 0; i < 4; i++) begin
      check("flt_mis", 32'(mis), 32'd1);
      check("flt_req", 32'(req), 32'd0);
      check("flt_vld", 32'(vld), 32'd0);
      check("flt_op", 32'(op), 32'h0);
      rdy = 1'b1; adv = 1'b1;
      step(1);
    end
    rdy = 1'b0; adv = 1'b0;
    reset = 1'b0;
    step(1);
    check("flt_rst_mis", 32'(mis), 32'd0);
    reset = 1'b1;
    fetch0(32'h0040_0000, 32'h0000_0003);

    // reset in a fetch wait with late ready pulse
    advance(1'b0, 32'h0);
    step(2);
    check("pre_addr", addr, 32'h0040_0004);
    #2 reset = 1'b0;
    #1;
    check("ar_addr", addr, 32'h0040_0000);
    check("ar_req", 32'(req), 32'd1);
    rdy = 1'b1; rdata = 32'h0000_0013;
    step(1);
    rdy = 1'b0;
    check("ar_vld", 32'(vld), 32'd0);
    check("ar_pc", pc, 32'h0);
    check("ar_ins", instr, 32'h0);
    check("ar_op", 32'(op), 32'h0);
    check("ar_mis", 32'(mis), 32'd0);
    reset = 1'b1;
    step(1);
    check("post_vld", 32'(vld), 32'd0);
    fetch0(32'h0040_0000, 32'h0000_0093);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage feeding the control unit and the rest of the single-cycle datapath. Holds the program counter, requests 32-bit instruction words from instruction memory over a ready-based handshake, and holds the current instruction stable until the core signals it has executed it. Exposes the opcode field gated so that the control unit decodes an all-zero (no-write, no-memory) control word whenever no valid instruction is held. Next-PC selection takes the branch/jump decision from the execute side.

## Interface
- RESET_PC, 32'h0040_0000, address of the first fetch after reset
- ADDR_WIDTH, 32, width of PC and memory address

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Advance_i  in  1  core has completed the held instruction; load next PC
- Branch_Taken_i  in  1  next PC is Branch_Target_i instead of PC+4 (sampled with Advance_i)
- Branch_Target_i  in  ADDR_WIDTH  branch/jump target address
- Mem_Req_o  out  1  fetch request to instruction memory
- Mem_Addr_o  out  ADDR_WIDTH  fetch address, stable while Mem_Req_o=1
- Mem_Ready_i  in  1  memory returns Mem_Rdata_i this cycle
- Mem_Rdata_i  in  32  instruction word
- PC_o  out  ADDR_WIDTH  address of the held instruction
- Instr_o  out  32  held instruction word
- OP_o  out  7  Instr_o[6:0] when Instr_Valid_o=1, else 7'h00; drives control unit opcode input
- Instr_Valid_o  out  1  Instr_o/PC_o/OP_o are valid
- Misaligned_o  out  1  sticky fault: target address not word-aligned

## Operation
- States: FETCH, HOLD, FAULT.
- FETCH: Mem_Req_o=1, Mem_Addr_o=fetch_pc. On rising edge with Mem_Ready_i=1: Instr_o<=Mem_Rdata_i, PC_o<=fetch_pc, go HOLD. Otherwise stay (unbounded wait states).
- HOLD: Instr_Valid_o=1, Mem_Req_o=0. On edge with Advance_i=1: next = Branch_Taken_i ? Branch_Target_i : PC_o+4. If next[1:0]!=0 go FAULT, set Misaligned_o; else fetch_pc<=next, go FETCH.
- FAULT: Instr_Valid_o=0, Mem_Req_o=0, Misaligned_o=1; leaves only via reset.
- Advance_i/Branch_Taken_i ignored outside HOLD; Mem_Ready_i and Mem_Rdata_i ignored outside FETCH.
- PC+4 wraps modulo 2^ADDR_WIDTH (32'hFFFF_FFFC -> 32'h0000_0000), no fault.
- Branch target equal to PC_o (self-loop) is legal.

## Timing
- Reset (asynchronous assert, synchronous release on clk): state=FETCH, fetch_pc=RESET_PC, Mem_Addr_o=RESET_PC, Mem_Req_o=1, PC_o=0, Instr_o=0, OP_o=0, Instr_Valid_o=0, Misaligned_o=0.
- Reset mid-fetch or mid-hold aborts immediately; pending memory response discarded.
- Zero-wait memory (Mem_Ready_i high in first request cycle): Instr_Valid_o rises one cycle after request; peak throughput one instruction per two cycles.
- Instr_Valid_o falls the cycle after Advance_i is accepted; Instr_o and PC_o retain last values but OP_o is forced to 7'h00.
- Mem_Req_o and Instr_Valid_o are decoded from registered state only; no combinational path from any input to any output.

## Structure
- Shared package riscv_pkg: opcode constants (R_Type 7'h33, I_Type_LOGIC 7'h13, U_Type_LUI 7'h37, S_Type_SW 7'h23, I_Mem_Type_LW 7'h03, J_Type_JAL 7'h6F, B_Type 7'h63), fetch state encoding, default RESET_PC.
- One sub-module: fetch_pc_reg, ADDR_WIDTH register with async active-low reset to RESET_PC and load enable.

## Test plan
- Reset release, memory Mem_Ready_i=1 immediately, Mem_Rdata_i=32'h00500093 -> Mem_Addr_o=32'h0040_0000; next cycle Instr_Valid_o=1, OP_o=7'h13, PC_o=32'h0040_0000.
- 3 wait states before Mem_Ready_i -> Mem_Req_o held 4 cycles with constant address; Instr_Valid_o=0, OP_o=7'h00 throughout.
- Advance_i with Branch_Taken_i=0 at PC 32'h0040_0008 -> next fetch address 32'h0040_000C; with Branch_Taken_i=1, target 32'h0040_0100 -> fetch 32'h0040_0100.
- Advance_i, Branch_Taken_i=1, target 32'h0040_0102 -> Misaligned_o=1, Mem_Req_o=0 permanently until reset, which restores fetch at RESET_PC.
- PC_o=32'hFFFF_FFFC, Advance_i, no branch -> fetch 32'h0000_0000, Misaligned_o=0.
- reset asserted during FETCH wait with late Mem_Ready_i pulse -> pulse ignored, outputs at reset values, first post-reset fetch at RESET_PC.
